// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard request and pipeline-control response bundle
interface hazard_scoreboard_if #(
  parameter int AW = 5
);
  logic                 id_valid;
  logic [AW-1:0]        id_rs;
  logic [AW-1:0]        id_rt;
  logic [1:0]           id_rs_use;
  logic [1:0]           id_rt_use;
  logic                 id_wr_en;
  logic [AW-1:0]        id_wr_addr;
  logic [1:0]           id_wr_class;
  logic [1:0]           id_pcsrc;
  logic                 branch_taken;
  logic                 flush_all;
  logic                 stall_if_id;
  logic                 bubble_ex;
  logic                 flush_if;
  logic [(1<<AW)-1:0]   pending;
  logic [31:0]          stall_cycles;

  // The decode stage drives the instruction description and consumes the controls
  modport master (
    output id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_wr_en, id_wr_addr,
           id_wr_class, id_pcsrc, branch_taken, flush_all,
    input  stall_if_id, bubble_ex, flush_if, pending, stall_cycles
  );

  // The scoreboard consumes the instruction description and produces the controls
  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_wr_en, id_wr_addr,
           id_wr_class, id_pcsrc, branch_taken, flush_all,
    output stall_if_id, bubble_ex, flush_if, pending, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard producing ID stall/bubble/flush
module hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int CNT_W    = 3,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int MUL_LAT  = 4
) (
  input logic            clk,
  input logic            reset,
  hazard_scoreboard_if.slave sb
);
  localparam int NumRegs = 1 << AW;

  // cnt[r] = cycles until the in-flight result for r can be forwarded at EX
  logic [CNT_W-1:0]   cnt [NumRegs];
  logic [CNT_W-1:0]   rsCnt, rtCnt, wrCnt, wrLat;
  logic               rsHazard, rtHazard, wawHazard;
  logic               stall, issue;
  logic [NumRegs-1:0] pendingBits;
  logic [31:0]        stallCount;

  function automatic logic [CNT_W-1:0] classLatency(input logic [1:0] wrClass);
    case (wrClass)
      2'd0:    classLatency = CNT_W'(ALU_LAT);
      2'd1:    classLatency = CNT_W'(LOAD_LAT);
      default: classLatency = CNT_W'(MUL_LAT);   // reserved class behaves as multiply
    endcase
  endfunction

  // An operand needed at a later stage tolerates a correspondingly larger count
  function automatic logic useHazard(input logic [1:0] useStage, input logic [CNT_W-1:0] count);
    case (useStage)
      2'd1:    useHazard = (count != '0);
      2'd2:    useHazard = (32'(count) > 32'd1);
      2'd3:    useHazard = (32'(count) > 32'd2);
      default: useHazard = 1'b0;
    endcase
  endfunction

  // Hazard detection and pipeline controls, zero-latency from inputs and counts
  always_comb begin
    rsCnt     = cnt[sb.id_rs];
    rtCnt     = cnt[sb.id_rt];
    wrCnt     = cnt[sb.id_wr_addr];
    wrLat     = classLatency(sb.id_wr_class);
    rsHazard  = useHazard(sb.id_rs_use, rsCnt);
    rtHazard  = useHazard(sb.id_rt_use, rtCnt);
    wawHazard = sb.id_wr_en && (sb.id_wr_addr != '0) && (wrCnt > wrLat);
    stall     = sb.id_valid && !sb.flush_all && (rsHazard || rtHazard || wawHazard);
    issue     = sb.id_valid && !sb.flush_all && !stall;
  end

  assign sb.stall_if_id  = stall;
  assign sb.bubble_ex    = stall || sb.flush_all;
  assign sb.flush_if     = issue && ((sb.id_pcsrc[1]) || (sb.id_pcsrc == 2'd1 && sb.branch_taken));
  assign sb.pending      = pendingBits;
  assign sb.stall_cycles = stallCount;

  // Pending flags are a direct view of the counters
  always_comb begin
    pendingBits = '0;
    for (int r = 0; r < NumRegs; r++) begin
      pendingBits[r] = (cnt[r] != '0);
    end
  end

  // Countdown per register; an issuing writer reloads its destination instead of decrementing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NumRegs; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NumRegs; r++) begin
        if (issue && sb.id_wr_en && (sb.id_wr_addr == AW'(r))) begin
          cnt[r] <= wrLat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
    end else if (stall && (stallCount != 32'hFFFF_FFFF)) begin
      stallCount <= stallCount + 32'd1;
    end
  end
endmodule
